// File: rtl/risc_pkg.sv
// Shared definitions for the multicycle RISC: jump encodings, displacement
// field bounds and the opcode slice positions seen by Controller.
package risc_pkg;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_REL  = 2'b01,
    JMP_REG  = 2'b10,
    JMP_RSVD = 2'b11
  } jump_e;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  // Displacement fields are sign-extended from these MSBs down to bit 0
  localparam int DISP_J_MSB = 10;
  localparam int DISP_B_MSB = 7;

  localparam int INSM_MSB = 15;
  localparam int INSM_LSB = 8;
  localparam int INSL_MSB = 1;
  localparam int INSL_LSB = 0;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: register target, PC-relative jump,
// taken branch or sequential increment, all modulo 2^ADDR_W.
module fetch_next_pc
  import risc_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0]   pc,
  input  logic [DISP_J_MSB:0] disp_field,
  input  logic                branch,
  input  logic [1:0]          jump,
  input  logic [ADDR_W-1:0]   reg_target,
  output logic [ADDR_W-1:0]   pc_plus1,
  output logic [ADDR_W-1:0]   next_pc
);

  logic [ADDR_W-1:0] disp_j;
  logic [ADDR_W-1:0] disp_b;

  assign pc_plus1 = pc + ADDR_W'(1);
  assign disp_j   = {{(ADDR_W-DISP_J_MSB-1){disp_field[DISP_J_MSB]}}, disp_field};
  assign disp_b   = {{(ADDR_W-DISP_B_MSB-1){disp_field[DISP_B_MSB]}},
                     disp_field[DISP_B_MSB:0]};

  // Register jump beats relative jump beats branch; reserved acts as no-jump
  // but still suppresses the branch.
  always_comb begin
    next_pc = pc_plus1;
    unique case (jump_e'(jump))
      JMP_REG:  next_pc = reg_target;
      JMP_REL:  next_pc = pc_plus1 + disp_j;
      JMP_RSVD: next_pc = pc_plus1;
      JMP_NONE: if (branch) next_pc = pc_plus1 + disp_b;
      default:  next_pc = pc_plus1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC, IR, the sticky halt flag and the retire counter;
// Controller sequences every update through its strobes.
module instr_fetch_unit
  import risc_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter int          DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              Buff_PC,
  input  logic              Buff_MEMIns,
  input  logic              Branch,
  input  logic [1:0]        Jump,
  input  logic              Done,
  input  logic [ADDR_W-1:0] RegTarget,
  output logic [ADDR_W-1:0] IMem_Addr,
  input  logic [DATA_W-1:0] IMem_Data,
  output logic [DATA_W-1:0] Ins,
  output logic [7:0]        InsM,
  output logic [1:0]        InsL,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCplus1,
  output logic              Halted,
  output logic [15:0]       RetireCnt
);

  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic              halted_q;
  logic [15:0]       retire_q;
  logic [ADDR_W-1:0] next_pc;

  fetch_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc         (pc_q),
    .disp_field (ir_q[DISP_J_MSB:0]),
    .branch     (Branch),
    .jump       (Jump),
    .reg_target (RegTarget),
    .pc_plus1   (PCplus1),
    .next_pc    (next_pc)
  );

  // Done wins over the strobes in its own cycle, so the halting instruction
  // neither moves the PC nor counts as retired.
  always_ff @(posedge clk) begin
    if (Rst) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      halted_q <= 1'b0;
      retire_q <= '0;
    end else if (!halted_q) begin
      if (Done) begin
        halted_q <= 1'b1;
      end else begin
        if (Buff_MEMIns) ir_q <= IMem_Data;
        if (Buff_PC) begin
          pc_q <= next_pc;
          if (retire_q != 16'hFFFF) retire_q <= retire_q + 16'd1;
        end
      end
    end
  end

  assign IMem_Addr = pc_q;
  assign PC        = pc_q;
  assign Ins       = ir_q;
  assign InsM      = ir_q[INSM_MSB:INSM_LSB];
  assign InsL      = ir_q[INSL_MSB:INSL_LSB];
  assign Halted    = halted_q;
  assign RetireCnt = retire_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle synchronous instruction
// memory model; expected values are worked out by hand.
module tb_instr_fetch_unit;

  logic        clk;
  logic        Rst;
  logic        Buff_PC;
  logic        Buff_MEMIns;
  logic        Branch;
  logic [1:0]  Jump;
  logic        Done;
  logic [15:0] RegTarget;
  logic [15:0] IMem_Addr;
  logic [15:0] IMem_Data;
  logic [15:0] Ins;
  logic [7:0]  InsM;
  logic [1:0]  InsL;
  logic [15:0] PC;
  logic [15:0] PCplus1;
  logic        Halted;
  logic [15:0] RetireCnt;

  logic [15:0] mem [0:255];
  int          errors = 0;
  int          checks = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .Rst         (Rst),
    .Buff_PC     (Buff_PC),
    .Buff_MEMIns (Buff_MEMIns),
    .Branch      (Branch),
    .Jump        (Jump),
    .Done        (Done),
    .RegTarget   (RegTarget),
    .IMem_Addr   (IMem_Addr),
    .IMem_Data   (IMem_Data),
    .Ins         (Ins),
    .InsM        (InsM),
    .InsL        (InsL),
    .PC          (PC),
    .PCplus1     (PCplus1),
    .Halted      (Halted),
    .RetireCnt   (RetireCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) IMem_Data <= mem[IMem_Addr[7:0]];

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of Controller strobes, then settle just after the edge.
  task automatic applyStimulus(input logic bpc, input logic bmem, input logic br,
                               input logic [1:0] jmp, input logic dn,
                               input logic [15:0] tgt);
    Buff_PC = bpc; Buff_MEMIns = bmem; Branch = br;
    Jump = jmp; Done = dn; RegTarget = tgt;
    @(posedge clk);
    #1;
    Buff_PC = 0; Buff_MEMIns = 0; Branch = 0; Jump = 2'b00; Done = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h0800;
    mem[8'h10] = 16'hC1FC;
    mem[8'h20] = 16'h8005;
    mem[8'h34] = 16'hC105;
    mem[8'h40] = 16'hFFFF;
    IMem_Data = 16'h0000;
    Rst = 1; Buff_PC = 1; Buff_MEMIns = 1; Branch = 0; Jump = 2'b10; Done = 0;
    RegTarget = 16'h5555;
    @(posedge clk); #1;
    checkOutput("rst_pc_c1", 32'(PC), 32'h0000);
    @(posedge clk); #1;
    Rst = 0; Buff_PC = 0; Buff_MEMIns = 0; Jump = 2'b00;
    checkOutput("rst_pc", 32'(PC), 32'h0000);
    checkOutput("rst_ir", 32'(Ins), 32'h0000);
    checkOutput("rst_halted", 32'(Halted), 32'h0);
    checkOutput("rst_cnt", 32'(RetireCnt), 32'h0000);

    // Sequential fetch of LHI at 0
    applyStimulus(0, 1, 0, 2'b00, 0, 16'h0);
    checkOutput("seq_insm", 32'(InsM), 32'h08);
    checkOutput("seq_ir", 32'(Ins), 32'h0800);
    applyStimulus(1, 0, 0, 2'b00, 0, 16'h0);
    checkOutput("seq_pc", 32'(PC), 32'h0001);
    checkOutput("seq_cnt", 32'(RetireCnt), 32'h0001);

    // Branch from 0010 with BEQ disp -4
    applyStimulus(1, 0, 0, 2'b10, 0, 16'h0010);
    applyStimulus(0, 0, 0, 2'b00, 0, 16'h0);
    applyStimulus(0, 1, 0, 2'b00, 0, 16'h0);
    checkOutput("br_insm", 32'(InsM), 32'hC1);
    checkOutput("br_insl", 32'(InsL), 32'h0);
    applyStimulus(1, 0, 1, 2'b00, 0, 16'h0);
    checkOutput("br_taken", 32'(PC), 32'h000D);
    applyStimulus(1, 0, 0, 2'b10, 0, 16'h0010);
    applyStimulus(1, 0, 0, 2'b00, 0, 16'h0);
    checkOutput("br_not_taken", 32'(PC), 32'h0011);
    applyStimulus(0, 0, 1, 2'b01, 0, 16'h9999);
    checkOutput("no_commit_hold", 32'(PC), 32'h0011);
    applyStimulus(1, 0, 1, 2'b11, 0, 16'h0);
    checkOutput("jmp_rsvd", 32'(PC), 32'h0012);
    checkOutput("cnt_6", 32'(RetireCnt), 32'h0006);

    // Relative and register jumps from 0020
    applyStimulus(1, 0, 0, 2'b10, 0, 16'h0020);
    applyStimulus(0, 0, 0, 2'b00, 0, 16'h0);
    applyStimulus(0, 1, 0, 2'b00, 0, 16'h0);
    checkOutput("jmp_pcplus1", 32'(PCplus1), 32'h0021);
    checkOutput("jmp_imem_addr", 32'(IMem_Addr), 32'h0020);
    checkOutput("jmp_ir", 32'(Ins), 32'h8005);
    applyStimulus(1, 0, 1, 2'b01, 0, 16'h0);
    checkOutput("jmp_rel", 32'(PC), 32'h0026);
    applyStimulus(1, 0, 0, 2'b10, 0, 16'h1234);
    checkOutput("jmp_reg", 32'(PC), 32'h1234);

    // Simultaneous commit and IR load: PC uses old IR 8005
    applyStimulus(0, 0, 0, 2'b00, 0, 16'h0);
    applyStimulus(1, 1, 0, 2'b01, 0, 16'h0);
    checkOutput("simul_pc", 32'(PC), 32'h123A);
    checkOutput("simul_ir", 32'(Ins), 32'hC105);
    checkOutput("cnt_10", 32'(RetireCnt), 32'h000A);

    // Wrap-around
    applyStimulus(1, 0, 0, 2'b10, 0, 16'hFFFF);
    checkOutput("wrap_pcplus1", 32'(PCplus1), 32'h0000);
    applyStimulus(1, 0, 0, 2'b00, 0, 16'h0);
    checkOutput("wrap_inc", 32'(PC), 32'h0000);
    mem[8'h00] = 16'h87FF;
    applyStimulus(0, 0, 0, 2'b00, 0, 16'h0);
    applyStimulus(0, 1, 0, 2'b00, 0, 16'h0);
    checkOutput("wrap_ir", 32'(Ins), 32'h87FF);
    applyStimulus(1, 0, 0, 2'b01, 0, 16'h0);
    checkOutput("wrap_rel_neg", 32'(PC), 32'h0000);

    // Halt
    applyStimulus(1, 0, 0, 2'b10, 0, 16'h0040);
    checkOutput("cnt_14", 32'(RetireCnt), 32'h000E);
    applyStimulus(1, 0, 0, 2'b00, 1, 16'h0);
    checkOutput("halt_flag", 32'(Halted), 32'h1);
    checkOutput("halt_pc", 32'(PC), 32'h0040);
    checkOutput("halt_cnt", 32'(RetireCnt), 32'h000E);
    applyStimulus(0, 0, 0, 2'b00, 0, 16'h0);
    applyStimulus(1, 1, 0, 2'b10, 0, 16'h7777);
    checkOutput("frozen_pc", 32'(PC), 32'h0040);
    checkOutput("frozen_ir", 32'(Ins), 32'h87FF);
    checkOutput("frozen_cnt", 32'(RetireCnt), 32'h000E);
    checkOutput("halt_sticky", 32'(Halted), 32'h1);
    Rst = 1;
    applyStimulus(1, 0, 0, 2'b00, 0, 16'h0);
    Rst = 0;
    checkOutput("rst_unhalt", 32'(Halted), 32'h0);
    checkOutput("rst_pc_after_halt", 32'(PC), 32'h0000);
    checkOutput("rst_cnt_after_halt", 32'(RetireCnt), 32'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage of the multicycle RISC, directly upstream of Controller. Holds the PC and the instruction register (IR), and drives instruction memory. Presents InsM/InsL to Controller and the full instruction word to the datapath. Computes the next PC from Controller's Buff_PC/Branch/Jump strobes; freezes on Done (HLT).

Parameters:
ADDR_W, 16, PC / instruction-memory address width
DATA_W, 16, instruction width (opcode fields fixed at 16-bit layout)
RESET_PC, 16'h0000, PC value after reset

Ports:
clk  in  1  system clock, all state on rising edge
Rst  in  1  reset, synchronous active-high
Buff_PC  in  1  from Controller: commit next PC this cycle (last stage of instruction)
Buff_MEMIns  in  1  from Controller: latch IMem_Data into IR
Branch  in  1  from Controller: conditional branch taken (flag evaluation already done upstream)
Jump  in  2  from Controller: 00 none, 01 PC-relative jump, 10 register jump, 11 reserved
Done  in  1  from Controller: HLT reached
RegTarget  in  ADDR_W  register-file read value used as target for Jump=10 (JR/JALrr)
IMem_Addr  out  ADDR_W  instruction memory address (= PC)
IMem_Data  in  DATA_W  instruction memory read data, 1-cycle synchronous read latency
Ins  out  DATA_W  current IR contents
InsM  out  8  IR[15:8] to Controller
InsL  out  2  IR[1:0] to Controller
PC  out  ADDR_W  current PC
PCplus1  out  ADDR_W  PC+1, link value for JALrl/JALrr write-back
Halted  out  1  high once Done accepted
RetireCnt  out  16  count of committed instructions, debug

Behaviour:
- Decided: one clock clk; reset Rst is synchronous and active-high.
- Reset (Rst high at rising edge, any time incl. mid-instruction): PC<=RESET_PC, IR<=16'h0000, Halted<=0, RetireCnt<=0. Rst overrides all other inputs.
- Outputs are register-driven: IMem_Addr=PC; PCplus1=PC+1 mod 2^ADDR_W; InsM/InsL/Ins combinational slices of IR.
- IR: on Buff_MEMIns=1 and Halted=0, IR<=IMem_Data. Controller pulses Buff_MEMIns ≥1 cycle after PC settles; block does not check memory timing.
- Next-PC selection on Buff_PC=1 and Halted=0, priority order:
  Jump=10 -> RegTarget
  Jump=01 -> PC+1+sext(IR[10:0])
  Jump=11 -> PC+1 (reserved, no error)
  Jump=00 and Branch=1 -> PC+1+sext(IR[7:0])
  else -> PC+1
- All PC arithmetic modulo 2^ADDR_W: 16'hFFFF+1 -> 16'h0000; negative offsets wrap.
- Branch/Jump ignored when Buff_PC=0; PC holds.
- Simultaneous Buff_PC and Buff_MEMIns: IR loads IMem_Data addressed by old PC; PC updates using old IR.
- RetireCnt: +1 per accepted Buff_PC, saturates at 16'hFFFF.
- Done: Halted<=1 on first rising edge with Done=1; sticky until Rst. Done with Buff_PC in the same cycle: PC not updated, RetireCnt not incremented. While Halted, Buff_PC and Buff_MEMIns ignored; PC/IR frozen.
- No internal FSM besides Halted; cycle sequencing owned by Controller.

Decomposition:
- Shared package risc_pkg: Jump encodings (JMP_NONE=2'b00, JMP_REL=2'b01, JMP_REG=2'b10), displacement field bounds (DISP_J_MSB=10, DISP_B_MSB=7), RESET_PC default, opcode slice positions for InsM/InsL.
- One sub-module fetch_next_pc: combinational next-PC mux plus sign-extend/add; parent holds PC, IR, Halted, RetireCnt.

Test Plan:
- Reset: Rst high 2 cycles with Buff_PC=1 -> PC=0000, IR=0000, Halted=0, RetireCnt=0; PC unchanged during reset.
- Sequential fetch: IMem returns 16'h0800 (LHI) at 0; Buff_MEMIns then Buff_PC -> InsM=8'h08, PC=0001, RetireCnt=1.
- Branch: PC=0010, IR=16'hC1FC (BEQ disp -4), Branch=1, Buff_PC -> PC=000D; same with Branch=0 -> PC=0011.
- Jumps: PC=0020, IR=16'h8005, Jump=01 -> PC=0026; Jump=10, RegTarget=1234 -> PC=1234; PCplus1 before commit = 0021.
- Wrap: PC=FFFF, Buff_PC, Jump=00 -> PC=0000; IR=16'h87FF (disp -1), Jump=01 from 0000 -> PC=0000.
- Halt: Done=1 with Buff_PC=1 at PC=0040 -> Halted=1, PC stays 0040, RetireCnt unchanged; later Buff_PC/Buff_MEMIns no effect; Rst clears Halted and sets PC=0000.
